// File: rtl/axis_sogi_pll_pkg.sv
// Shared definitions for the SOGI-PLL sampling path.
//   EDGE_FALL / EDGE_RISE : encodings of the edge_sel input
//   eff_ratio()           : effective decimation ratio (0 and 1 both mean 1)
package axis_sogi_pll_pkg;

  localparam logic EDGE_FALL = 1'b0;
  localparam logic EDGE_RISE = 1'b1;

  function automatic int unsigned eff_ratio(input int unsigned decim);
    return (decim < 2) ? 1 : decim;
  endfunction

endpackage

// File: rtl/axis_valid_strobe_gen_edge_sync_detect.sv
// Synchronises an asynchronous slow clock into Clk and flags a selectable edge.
// Ports:
//   Clk, Resetn : system clock, synchronous active-low reset
//   async_in    : signal asynchronous to Clk
//   edge_sel    : EDGE_RISE / EDGE_FALL
//   edge_pulse  : one-cycle pulse on the selected edge of the synchronised input
module edge_sync_detect
  import axis_sogi_pll_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic Clk,
  input  logic Resetn,
  input  logic async_in,
  input  logic edge_sel,
  output logic edge_pulse
);

  localparam int SUP_W = $clog2(SYNC_STAGES + 2);
  localparam logic [SUP_W-1:0] SUP_INIT = SUP_W'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ctrl_s;
  logic                   ctrl_d;
  logic [SUP_W-1:0]       sup_cnt;
  logic                   raw_edge;

  assign ctrl_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge Clk) begin
    if (!Resetn) begin
      sync_q  <= '0;
      ctrl_d  <= 1'b0;
      sup_cnt <= SUP_INIT;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      ctrl_d <= ctrl_s;
      // The synchroniser restarts from 0, so an input already high would look
      // like a rising edge while the pipeline fills; hold off until it settles.
      if (sup_cnt != '0) sup_cnt <= sup_cnt - SUP_W'(1);
    end
  end

  assign raw_edge   = (edge_sel == EDGE_RISE) ? (ctrl_s & ~ctrl_d) : (~ctrl_s & ctrl_d);
  assign edge_pulse = raw_edge & (sup_cnt == '0);

endmodule

// File: rtl/axis_valid_strobe_gen.sv
// Multi-channel AXI-Stream valid-strobe generator.
// Ports:
//   Clk, Resetn  : system clock, synchronous active-low reset
//   clk_control  : slow control clock (asynchronous), edge source
//   enable       : allow strobes
//   edge_sel     : 0 falling, 1 rising
//   decim        : one strobe per decim edges (0/1 = every edge)
//   m_valid/m_ready : per-channel handshake
//   tick         : one-cycle pulse per strobe
//   overrun      : sticky per-channel overrun flags
//   overrun_cnt  : saturating count of strobe cycles with any overrun
//   clr_overrun  : clears overrun and overrun_cnt
module axis_valid_strobe_gen
  import axis_sogi_pll_pkg::*;
#(
  parameter int N_CH        = 2,
  parameter int SYNC_STAGES = 2,
  parameter int DECIM_W     = 8,
  parameter int CNT_W       = 16
) (
  input  logic               Clk,
  input  logic               Resetn,
  input  logic               clk_control,
  input  logic               enable,
  input  logic               edge_sel,
  input  logic [DECIM_W-1:0] decim,
  output logic [N_CH-1:0]    m_valid,
  input  logic [N_CH-1:0]    m_ready,
  output logic               tick,
  output logic [N_CH-1:0]    overrun,
  output logic [CNT_W-1:0]   overrun_cnt,
  input  logic               clr_overrun
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic               edge_pulse;
  logic [DECIM_W-1:0] dcnt;
  logic [DECIM_W-1:0] eff_m1;
  logic               strobe;
  logic [N_CH-1:0]    valid_nxt;
  logic [N_CH-1:0]    ovr_ev;
  logic               any_ovr;

  edge_sync_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge (
    .Clk       (Clk),
    .Resetn    (Resetn),
    .async_in  (clk_control),
    .edge_sel  (edge_sel),
    .edge_pulse(edge_pulse)
  );

  assign eff_m1 = DECIM_W'(eff_ratio(32'(decim)) - 1);
  // >= rather than == so a ratio lowered below the running count strobes on
  // the next edge instead of wrapping the counter.
  assign strobe = edge_pulse & enable & (dcnt >= eff_m1);

  always_ff @(posedge Clk) begin
    if (!Resetn) begin
      dcnt <= '0;
    end else if (!enable) begin
      dcnt <= '0;
    end else if (edge_pulse) begin
      dcnt <= strobe ? '0 : dcnt + DECIM_W'(1);
    end
  end

  // A strobe always leaves valid high: either a fresh issue, a re-issue after a
  // same-cycle handshake, or a held valid that was overrun.
  always_comb begin
    valid_nxt = m_valid;
    ovr_ev    = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (strobe) begin
        valid_nxt[i] = 1'b1;
        ovr_ev[i]    = m_valid[i] & ~m_ready[i];
      end else if (m_valid[i] & m_ready[i]) begin
        valid_nxt[i] = 1'b0;
      end
    end
  end

  assign any_ovr = |ovr_ev;

  always_ff @(posedge Clk) begin
    if (!Resetn) begin
      m_valid     <= '0;
      tick        <= 1'b0;
      overrun     <= '0;
      overrun_cnt <= '0;
    end else begin
      m_valid <= valid_nxt;
      tick    <= strobe;
      // A new overrun in the clearing cycle survives the clear.
      if (clr_overrun) begin
        overrun     <= ovr_ev;
        overrun_cnt <= any_ovr ? CNT_W'(1) : '0;
      end else begin
        overrun <= overrun | ovr_ev;
        if (any_ovr && overrun_cnt != CNT_MAX) overrun_cnt <= overrun_cnt + CNT_W'(1);
      end
    end
  end

endmodule
